// File: rtl/btn_beep_ctrl_pkg.sv
// Shared buzzer package: button FSM encoding, default timing constants
// (50 MHz system clock) and tone divider constants for the tone generator.
package btn_beep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 32'd100_000_000;
  localparam int unsigned DEF_BEEP_SHORT      = 32'd5_000_000;
  localparam int unsigned DEF_BEEP_LONG       = 32'd25_000_000;

  localparam int unsigned TONE_CLK_HZ = 32'd50_000_000;
  localparam int unsigned TONE_HZ     = 32'd2_000;
  localparam int unsigned TONE_DIV    = TONE_CLK_HZ / (32'd2 * TONE_HZ);

  // Number of bits needed to hold the value n (at least one).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/btn_beep_ctrl_debounce.sv
// Reusable button debouncer: 2-flop synchronizer, stability counter and the
// debounced level register.
module btn_debounce
  import btn_beep_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive cycles the synchronized input disagrees with the level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/btn_beep_ctrl.sv
// Button-to-buzzer controller: debounced level, press / long-press pulses and
// a retriggerable beep timer driving the tone generator enable.
module btn_beep_ctrl
  import btn_beep_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned BEEP_SHORT      = DEF_BEEP_SHORT,
  parameter int unsigned BEEP_LONG       = DEF_BEEP_LONG
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_long,
  output logic beep_en
);

  localparam int unsigned HW = $clog2(LONG_CYCLES) + 32'd1;
  localparam int unsigned BW = cnt_width((BEEP_LONG > BEEP_SHORT) ? BEEP_LONG : BEEP_SHORT);

  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 32'd1);
  localparam logic [HW-1:0] HOLD_MAX  = {HW{1'b1}};
  localparam logic [HW-1:0] HOLD_ONE  = HW'(32'd1);
  localparam logic [BW-1:0] BEEP_S    = BW'(BEEP_SHORT);
  localparam logic [BW-1:0] BEEP_L    = BW'(BEEP_LONG);
  localparam logic [BW-1:0] BEEP_ONE  = BW'(32'd1);

  logic          deb_level;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          long_q, long_d;
  logic          beep_en_q, beep_en_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (deb_level)
  );

  // Next-state: press FSM with hold counter, then the beep timer fed by its pulses.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    level_d = deb_level;
    pulse_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
          pulse_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!level_q) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_LONG: begin
        if (!level_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LONG;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    // Loads restart the timer rather than adding to what is left.
    if (pulse_d) begin
      beep_d = BEEP_S;
    end else if (long_d) begin
      beep_d = BEEP_L;
    end else if (beep_q != '0) begin
      beep_d = beep_q - BEEP_ONE;
    end else begin
      beep_d = '0;
    end
    beep_en_d = (beep_d != '0);
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      beep_q    <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      long_q    <= 1'b0;
      beep_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      beep_q    <= beep_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      long_q    <= long_d;
      beep_en_q <= beep_en_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign btn_long  = long_q;
  assign beep_en   = beep_en_q;

endmodule

// File: tb/tb_btn_beep_ctrl.sv
// Directed bench for btn_beep_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// BEEP_SHORT=6, BEEP_LONG=10; t counts edges from the first edge sampling the press.
module tb_btn_beep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic btn_pulse;
  logic btn_long;
  logic beep_en;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  btn_beep_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .BEEP_SHORT      (6),
    .BEEP_LONG       (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_long  (btn_long),
    .beep_en   (beep_en)
  );

  task automatic check(input string tag, input string sig, input int t,
                       input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s.%s t=%0d observed=%b expected=%b", tag, sig, t, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int t, input logic lvl,
                           input logic pul, input logic lng, input logic bp);
    check(tag, "btn_level", t, btn_level, lvl);
    check(tag, "btn_pulse", t, btn_pulse, pul);
    check(tag, "btn_long",  t, btn_long,  lng);
    check(tag, "beep_en",   t, beep_en,   bp);
  endtask

  // Apply inputs for the next edge, then sample just after it.
  task automatic cycle(input logic raw, input logic r);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    btn_raw = 1'b0;
    rst     = 1'b1;

    // Reset dominates a pressed button.
    for (int t = 1; t <= 3; t++) begin
      cycle(1'b1, 1'b1);
      check_all("reset", t, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int t = 1; t <= 10; t++) cycle(1'b0, 1'b0);
    check_all("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press held into a long press, then released.
    for (int t = 1; t <= 50; t++) begin
      cycle(t <= 37, 1'b0);
      check_all("press_long", t, (t >= 7) && (t <= 43), t == 8, t == 28,
                ((t >= 8) && (t <= 13)) || ((t >= 28) && (t <= 37)));
    end
    for (int t = 1; t <= 10; t++) cycle(1'b0, 1'b0);

    // Three-cycle glitch is filtered completely.
    for (int t = 1; t <= 15; t++) begin
      cycle(t <= 3, 1'b0);
      check_all("glitch", t, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int t = 1; t <= 5; t++) cycle(1'b0, 1'b0);

    // Release one cycle short of the long threshold: no long pulse.
    for (int t = 1; t <= 35; t++) begin
      cycle(t <= 20, 1'b0);
      check_all("short_of_long", t, (t >= 7) && (t <= 26), t == 8, 1'b0,
                (t >= 8) && (t <= 13));
    end
    for (int t = 1; t <= 10; t++) cycle(1'b0, 1'b0);

    // Long press, quick re-press retriggers the beep, reset mid-beep while held.
    for (int t = 1; t <= 55; t++) begin
      cycle((t <= 21) || (t >= 28), (t == 37) || (t == 38));
      check_all("retrig_reset", t,
                ((t >= 7) && (t <= 27)) || ((t >= 34) && (t <= 36)) || (t >= 45),
                (t == 8) || (t == 35) || (t == 46),
                t == 28,
                ((t >= 8) && (t <= 13)) || ((t >= 28) && (t <= 36)) ||
                ((t >= 46) && (t <= 51)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
